rf_dbg_arbiter: RTL and testbench
=================================

RF_DBG_ARBITER -- requirements
Module: rf_dbg_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive blocked cycles a debug write waits before the CPU is stalled.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_we  input  1  CPU writeback write enable.
REQ-005 cpu_waddr  input  5  CPU writeback register index.
REQ-006 cpu_wdata  input  32  CPU writeback data.
REQ-007 cpu_stall  output  1  stall request to CPU; CPU holds its writeback stage for that cycle.
REQ-008 dbg_req  input  1  debug request valid; held high until dbg_ack.
REQ-009 dbg_we  input  1  1 = debug write, 0 = debug read; stable while dbg_req is high.
REQ-010 dbg_addr  input  5  debug register index; stable while dbg_req is high.
REQ-011 dbg_wdata  input  32  debug write data; stable while dbg_req is high.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 dbg_rdata  output  32  registered read result; valid while dbg_ack is high, held until the next read completes.
REQ-014 rf_we  output  1  register file write enable (single write port).
REQ-015 rf_waddr  output  5  register file write index.
REQ-016 rf_wdata  output  32  register file write data.
REQ-017 rf_dbg_raddr  output  5  register file debug read-port index (synchronous read, 1-cycle latency).
REQ-018 rf_dbg_rdata  input  32  register file debug read-port data.

Function
REQ-019 The FSM SHALL have states IDLE, WRQ, RDA, RDD and ACK.
REQ-020 IDLE: dbg_req&dbg_we -> WRQ; dbg_req&!dbg_we -> RDA; otherwise stay.
REQ-021 Default (no debug grant): rf_we=cpu_we, rf_waddr=cpu_waddr, rf_wdata=cpu_wdata, combinational pass-through.
REQ-022 WRQ grants the write port to debug in a cycle where cpu_we=0, or cpu_we=1 with cpu_waddr=0, or starve_cnt==STARVE_LIMIT; in a granted cycle rf_waddr=dbg_addr, rf_wdata=dbg_wdata, rf_we=(dbg_addr!=0), and next state is ACK.
REQ-023 WRQ not granted: starve_cnt increments by 1 and state stays WRQ; CPU write passes through unchanged.
REQ-024 cpu_stall SHALL be high only in WRQ with starve_cnt==STARVE_LIMIT and cpu_we=1 and cpu_waddr!=0, for exactly one cycle; the CPU write of that cycle is not performed (CPU re-presents it next cycle).
REQ-025 starve_cnt SHALL clear to 0 on every exit from WRQ; width ceil(log2(STARVE_LIMIT+1)) bits, never exceeds STARVE_LIMIT.
REQ-026 RDA: rf_dbg_raddr=dbg_addr; next state RDD.
REQ-027 RDD: dbg_rdata <= 0 if dbg_addr==0; else cpu_wdata if cpu_we=1 and cpu_waddr==dbg_addr (forwarding); else rf_dbg_rdata; next state ACK.
REQ-028 rf_dbg_raddr SHALL equal dbg_addr in RDA and RDD and 0 otherwise.
REQ-029 ACK: dbg_ack=1 for one cycle; next state IDLE unconditionally; a new request is sampled no earlier than the following cycle.
REQ-030 Debug reads never assert cpu_stall nor alter rf_we/rf_waddr/rf_wdata.
REQ-031 Debug write to x0 completes (ack issued) with no register file write.
REQ-032 Worst-case debug write latency from dbg_req rise to dbg_ack = STARVE_LIMIT+2 cycles; debug read latency = 3 cycles.

Reset
REQ-033 rst high at a rising edge SHALL force state=IDLE, starve_cnt=0, dbg_rdata=0; while rst is high, dbg_ack=0, cpu_stall=0, rf_we=0.
REQ-034 rst during any non-IDLE state SHALL abort the transaction with no ack and no further register file write.

Verification
REQ-035 Idle CPU, dbg write x5=0xDEADBEEF -> rf_we=1, rf_waddr=5 in the cycle after dbg_req rise; dbg_ack one cycle later; cpu_stall never high.
REQ-036 cpu_we=1 to x7 every cycle, dbg write x9=0x1234 -> 4 blocked cycles, then 1 cycle with cpu_stall=1 and rf_waddr=9; dbg_ack next cycle; x7 write resumes.
REQ-037 x3 preloaded 0xA5A5A5A5, dbg read x3 -> dbg_ack 3 cycles after dbg_req rise with dbg_rdata=0xA5A5A5A5.
REQ-038 dbg read x4 while CPU writes x4=0x55 in the RDD cycle -> dbg_rdata=0x55; dbg read x0 -> 0.
REQ-039 dbg write x0=0xFFFF -> dbg_ack pulses, rf_we stays 0 for the debug grant, x0 remains 0.
REQ-040 rst asserted in WRQ at starve_cnt=2 -> next cycle IDLE, no dbg_ack, cpu_stall=0, no debug write issued.

Source files
------------

// File: rtl/rf_dbg_arbiter.sv
// Debug-port arbiter for the register file: shares the single write port between
// CPU writeback and debug writes, and services debug reads with writeback forwarding.
module rf_dbg_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_dbg_raddr,
  input  logic [31:0] rf_dbg_rdata
);

  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WRQ  = 3'd1,
    RDA  = 3'd2,
    RDD  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             cpu_blocks;
  logic             wr_grant;
  logic             fwd_hit;

  // Write-port mux, stall and debug read index; reset gates every write-side effect.
  always_comb begin
    starved      = (starve_cnt == CNT_W'(STARVE_LIMIT));
    cpu_blocks   = cpu_we && (cpu_waddr != 5'd0);
    wr_grant     = (state == WRQ) && (!cpu_blocks || starved);
    fwd_hit      = cpu_we && (cpu_waddr == dbg_addr);
    rf_we        = cpu_we;
    rf_waddr     = cpu_waddr;
    rf_wdata     = cpu_wdata;
    cpu_stall    = 1'b0;
    rf_dbg_raddr = 5'd0;
    if (wr_grant) begin
      rf_we     = (dbg_addr != 5'd0);
      rf_waddr  = dbg_addr;
      rf_wdata  = dbg_wdata;
      cpu_stall = cpu_blocks;
    end
    if ((state == RDA) || (state == RDD)) begin
      rf_dbg_raddr = dbg_addr;
    end
    if (rst) begin
      rf_we     = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign dbg_ack = (state == ACK) && !rst;

  // Transaction sequencing, starvation counter and read result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dbg_rdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg_req) begin
            state <= dbg_we ? WRQ : RDA;
          end
        end
        WRQ: begin
          if (wr_grant) begin
            state      <= ACK;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        RDA: state <= RDD;
        RDD: begin
          // A same-cycle CPU writeback to the read index is newer than the array.
          if (dbg_addr == 5'd0) begin
            dbg_rdata <= 32'd0;
          end else if (fwd_hit) begin
            dbg_rdata <= cpu_wdata;
          end else begin
            dbg_rdata <= rf_dbg_rdata;
          end
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dbg_arbiter.sv
// Self-checking bench for rf_dbg_arbiter: register-file model plus a scoreboard
// of expected debug completions.
module tb_rf_dbg_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [4:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_dbg_raddr;
  logic [31:0] rf_dbg_rdata;

  always #5 clk = ~clk;

  rf_dbg_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_dbg_raddr(rf_dbg_raddr), .rf_dbg_rdata(rf_dbg_rdata)
  );

  // Register file: x0 hardwired, synchronous debug read port.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_we && (rf_waddr != 5'd0)) rf_mem[rf_waddr] <= rf_wdata;
    rf_dbg_rdata <= rf_mem[rf_dbg_raddr];
  end

  typedef struct {
    logic        rd;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every ack retires the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst && dbg_ack) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.rd) check("rd_data", dbg_rdata, mon_e.d);
        else if (mon_e.a != 5'd0) check("wr_rf", rf_mem[mon_e.a], mon_e.d);
      end
    end
  end

  task automatic dbg_txn(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] exp_d, input int exp_lat,
                         input int pulse_cyc, input logic [4:0] pa, input logic [31:0] pd,
                         output int grant_cyc, output int stall_cyc, output int stalls,
                         output int x0w);
    exp_t e;
    int   lat;
    int   got;
    e.rd = !we; e.a = a; e.d = exp_d;
    sb.push_back(e);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    lat = 0; got = 0; grant_cyc = -1; stall_cyc = -1; stalls = 0; x0w = 0;
    while (got == 0 && lat < 20) begin
      @(negedge clk);
      if (cpu_stall) begin stalls++; stall_cyc = lat; end
      if (we && rf_we && rf_waddr == a && rf_wdata == d) grant_cyc = lat;
      if (rf_we && rf_waddr == 5'd0) x0w++;
      if (dbg_ack) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
        if (pulse_cyc >= 0) begin
          cpu_we = (lat == pulse_cyc); cpu_waddr = pa; cpu_wdata = pd;
        end
      end
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    dbg_req = 1'b0;
    if (pulse_cyc >= 0) cpu_we = 1'b0;
  endtask

  int g, s, n, x;
  int acks, stl, w11;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    rf_dbg_rdata = 32'd0;
    rst = 1'b1; cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_raddr", 32'(rf_dbg_raddr), 32'd0);

    // CPU passthrough preloads x3 and x4
    @(posedge clk); #1;
    rst = 1'b0; cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("pass_we", 32'(rf_we), 32'd1);
    check("pass_waddr", 32'(rf_waddr), 32'd3);
    check("pass_wdata", rf_wdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    cpu_waddr = 5'd4; cpu_wdata = 32'h11;
    @(posedge clk); #1;
    cpu_we = 1'b0;

    // Idle CPU write
    dbg_txn("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2, -1, 5'd0, 32'd0, g, s, n, x);
    check("wr5_grant_cyc", 32'(g), 32'd1);
    check("wr5_stalls", 32'(n), 32'd0);

    // Starved write against a continuous CPU writeback stream
    cpu_we = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 32'h77;
    dbg_txn("wr9", 1'b1, 5'd9, 32'h1234, 32'h1234, LIM + 2, -1, 5'd0, 32'd0, g, s, n, x);
    check("wr9_grant_cyc", 32'(g), 32'(LIM + 1));
    check("wr9_stall_cyc", 32'(s), 32'(LIM + 1));
    check("wr9_stalls", 32'(n), 32'd1);
    @(negedge clk);
    check("wr9_resume_we", 32'(rf_we), 32'd1);
    check("wr9_resume_addr", 32'(rf_waddr), 32'd7);
    check("wr9_x7", rf_mem[7], 32'h77);

    // CPU writing x0 never blocks a debug write
    @(posedge clk); #1;
    cpu_waddr = 5'd0; cpu_wdata = 32'h5;
    dbg_txn("wr10", 1'b1, 5'd10, 32'hCAFE, 32'hCAFE, 2, -1, 5'd0, 32'd0, g, s, n, x);
    check("wr10_grant_cyc", 32'(g), 32'd1);
    check("wr10_stalls", 32'(n), 32'd0);
    cpu_we = 1'b0;

    // Reads: plain, forwarded, non-matching writeback, x0
    dbg_txn("rd3", 1'b0, 5'd3, 32'd0, 32'hA5A5A5A5, 3, -1, 5'd0, 32'd0, g, s, n, x);
    check("rd3_stalls", 32'(n), 32'd0);
    dbg_txn("rd4_fwd", 1'b0, 5'd4, 32'd0, 32'h55, 3, 2, 5'd4, 32'h55, g, s, n, x);
    dbg_txn("rd3_nofwd", 1'b0, 5'd3, 32'd0, 32'hA5A5A5A5, 3, 2, 5'd8, 32'h88, g, s, n, x);
    dbg_txn("rd0", 1'b0, 5'd0, 32'd0, 32'd0, 3, 2, 5'd0, 32'h99, g, s, n, x);
    check("rd_hold", dbg_rdata, 32'd0);

    // Debug write to x0 completes without a write
    dbg_txn("wr0", 1'b1, 5'd0, 32'hFFFF, 32'd0, 2, -1, 5'd0, 32'd0, g, s, n, x);
    check("wr0_x0_writes", 32'(x), 32'd0);
    check("wr0_stalls", 32'(n), 32'd0);

    // Reset while a write is starving at count 2
    cpu_we = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 32'h78;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'hBEEF;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("abort_ack", 32'(dbg_ack), 32'd0);
    check("abort_stall", 32'(cpu_stall), 32'd0);
    check("abort_rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dbg_req = 1'b0;
    acks = 0; stl = 0; w11 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dbg_ack) acks++;
      if (cpu_stall) stl++;
      if (rf_we && rf_waddr == 5'd11) w11++;
      @(posedge clk); #1;
    end
    check("abort_acks", 32'(acks), 32'd0);
    check("abort_stalls", 32'(stl), 32'd0);
    check("abort_x11_writes", 32'(w11), 32'd0);
    check("abort_x11", rf_mem[11], 32'd0);

    // Starvation count restarts from zero after the abort
    dbg_txn("wr11", 1'b1, 5'd11, 32'hBEEF, 32'hBEEF, LIM + 2, -1, 5'd0, 32'd0, g, s, n, x);
    check("wr11_stall_cyc", 32'(s), 32'(LIM + 1));
    check("wr11_stalls", 32'(n), 32'd1);
    cpu_we = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
